// File: rtl/world_top.sv
`timescale 1ns/1ps
`default_nettype none
// world_top: 10x20 cell world with a left-hand wall-following robot and a 640x480@60 VGA view.
// Rev 1.0
module world_top #(
  parameter int unsigned  STEP_CYCLES = 2,
  parameter logic [199:0] WALL_MAP    = {20'h00000, 20'h00000, 20'h00000, 20'h00000,
                                         20'h00F80, 20'h00F80, 20'h00F80,
                                         20'h00000, 20'h00000, 20'h00000}
) (
  input  logic       CLOCK_50,
  input  logic [3:0] KEY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int unsigned      CNT_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  localparam logic [2:0] ORI_N = 3'b000;
  localparam logic [2:0] ORI_S = 3'b001;
  localparam logic [2:0] ORI_E = 3'b010;
  localparam logic [2:0] ORI_W = 3'b011;

  logic rst;
  logic unused_keys;
  assign rst         = KEY[0];
  assign unused_keys = ^KEY[3:1];

  // Row r occupies WALL_MAP[(r-1)*20 +: 20], column c is bit c-1 of that slice.
  function automatic logic cell_is_wall(input logic [5:0] row, input logic [5:0] col);
    logic [7:0] idx;
    idx = ({2'b00, row} - 8'd1) * 8'd20 + {2'b00, col} - 8'd1;
    if (row == 6'd0 || row > 6'd10 || col == 6'd0 || col > 6'd20)
      cell_is_wall = 1'b1;
    else
      cell_is_wall = WALL_MAP[idx];
  endfunction

  function automatic logic [5:0] step_row(input logic [5:0] row, input logic [2:0] ori);
    case (ori)
      ORI_N:   step_row = row - 6'd1;
      ORI_S:   step_row = row + 6'd1;
      default: step_row = row;
    endcase
  endfunction

  function automatic logic [5:0] step_col(input logic [5:0] col, input logic [2:0] ori);
    case (ori)
      ORI_E:   step_col = col + 6'd1;
      ORI_W:   step_col = col - 6'd1;
      default: step_col = col;
    endcase
  endfunction

  // Step tick
  logic [CNT_W-1:0] step_cnt_q;
  logic             tick;
  assign tick = (step_cnt_q == CNT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (rst || tick)
      step_cnt_q <= '0;
    else
      step_cnt_q <= step_cnt_q + CNT_W'(1);
  end

  // Robot
  logic [5:0] robot_row, robot_row_d;
  logic [5:0] robot_column, robot_column_d;
  logic [2:0] robot_orientation, robot_orientation_d;
  logic [2:0] left_ori, right_ori;
  logic [5:0] left_row, left_col, front_row, front_col;

  always_comb begin
    left_ori  = ORI_W;
    right_ori = ORI_E;
    case (robot_orientation)
      ORI_N:   begin left_ori = ORI_W; right_ori = ORI_E; end
      ORI_E:   begin left_ori = ORI_N; right_ori = ORI_S; end
      ORI_S:   begin left_ori = ORI_E; right_ori = ORI_W; end
      ORI_W:   begin left_ori = ORI_S; right_ori = ORI_N; end
      default: begin left_ori = ORI_W; right_ori = ORI_E; end
    endcase
  end

  assign left_row  = step_row(robot_row, left_ori);
  assign left_col  = step_col(robot_column, left_ori);
  assign front_row = step_row(robot_row, robot_orientation);
  assign front_col = step_col(robot_column, robot_orientation);

  always_comb begin
    robot_row_d         = robot_row;
    robot_column_d      = robot_column;
    robot_orientation_d = robot_orientation;
    if (tick) begin
      if (!cell_is_wall(left_row, left_col)) begin
        robot_row_d         = left_row;
        robot_column_d      = left_col;
        robot_orientation_d = left_ori;
      end else if (!cell_is_wall(front_row, front_col)) begin
        robot_row_d    = front_row;
        robot_column_d = front_col;
      end else begin
        robot_orientation_d = right_ori;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      robot_row         <= 6'd10;
      robot_column      <= 6'd1;
      robot_orientation <= ORI_N;
    end else begin
      robot_row         <= robot_row_d;
      robot_column      <= robot_column_d;
      robot_orientation <= robot_orientation_d;
    end
  end

  // VGA timing: one pixel every second clock
  logic       pix_en_q;
  logic [9:0] h_q, v_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      pix_en_q <= 1'b0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
    end else begin
      pix_en_q <= ~pix_en_q;
      if (pix_en_q) begin
        if (h_q == 10'd799) begin
          h_q <= 10'd0;
          v_q <= (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
        end else begin
          h_q <= h_q + 10'd1;
        end
      end
    end
  end

  logic [5:0]  cell_row, cell_col;
  logic        hs_d, vs_d;
  logic [23:0] rgb_d;
  assign cell_col = {1'b0, h_q[9:5]} + 6'd1;
  assign cell_row = {1'b0, v_q[9:5]} + 6'd1;

  always_comb begin
    hs_d  = !(h_q >= 10'd656 && h_q <= 10'd751);
    vs_d  = !(v_q == 10'd490 || v_q == 10'd491);
    rgb_d = 24'h000000;
    if (h_q < 10'd640 && v_q < 10'd320) begin
      if (cell_row == robot_row && cell_col == robot_column)
        rgb_d = 24'hFF0000;
      else if (cell_is_wall(cell_row, cell_col))
        rgb_d = 24'h808080;
      else
        rgb_d = 24'hFFFFFF;
    end
  end

  // One register stage for sync and colour keeps them aligned.
  logic        hs_q, vs_q;
  logic [23:0] rgb_q;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      rgb_q <= 24'h000000;
    end else begin
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      rgb_q <= rgb_d;
    end
  end

  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_R  = rgb_q[23:16];
  assign VGA_G  = rgb_q[15:8];
  assign VGA_B  = rgb_q[7:0];

endmodule
`default_nettype wire

// File: tb/tb_world_top.sv
`timescale 1ns/1ps
`default_nettype none
// tb_world_top: vector table, hand sequences and randomized resets against a trajectory/pixel model.
// Rev 1.0
module tb_world_top;

  localparam int STEP = 2;
  localparam int NACT = 4096;
  localparam logic [199:0] MAP_D = {20'h0, 20'h0, 20'h0, 20'h0, 20'h00F80, 20'h00F80, 20'h00F80,
                                    20'h0, 20'h0, 20'h0};
  localparam logic [199:0] MAP_A = {20'h0, 20'h0, 20'h0, 20'h0, {6{20'hFFFFF}}};
  localparam logic [199:0] MAP_B = {20'h0, 20'h0, 20'h0, 20'h00100, {6{20'hFFFFF}}};

  typedef struct {
    int r;
    int c;
    int o;
  } rstate_t;

  typedef struct {
    int dut;
    int act;
    int row;
    int col;
    int ori;
  } vec_t;

  logic            clk;
  logic [3:0]      KEY;
  logic [2:0]      hs, vs;
  logic [2:0][7:0] red, grn, blu;

  int      k;
  int      cyc;
  bit      mon_en;
  int      n_cmp;
  int      n_fail;
  rstate_t traj [3][NACT+1];
  vec_t    tbl [10];
  rstate_t mon_s;
  logic [31:0] mon_ev;

  world_top #(.STEP_CYCLES(STEP)) u_d (
    .CLOCK_50(clk), .KEY(KEY), .VGA_HS(hs[0]), .VGA_VS(vs[0]),
    .VGA_R(red[0]), .VGA_G(grn[0]), .VGA_B(blu[0]));
  world_top #(.STEP_CYCLES(STEP), .WALL_MAP(MAP_A)) u_a (
    .CLOCK_50(clk), .KEY(KEY), .VGA_HS(hs[1]), .VGA_VS(vs[1]),
    .VGA_R(red[1]), .VGA_G(grn[1]), .VGA_B(blu[1]));
  world_top #(.STEP_CYCLES(STEP), .WALL_MAP(MAP_B)) u_b (
    .CLOCK_50(clk), .KEY(KEY), .VGA_HS(hs[2]), .VGA_VS(vs[2]),
    .VGA_R(red[2]), .VGA_G(grn[2]), .VGA_B(blu[2]));

  always #10 clk = ~clk;

  // Edges since the last edge that saw reset.
  always @(posedge clk) begin
    k   <= KEY[0] ? 0 : k + 1;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [199:0] map_of(input int d);
    case (d)
      0:       return MAP_D;
      1:       return MAP_A;
      default: return MAP_B;
    endcase
  endfunction

  function automatic bit wall_at(input logic [199:0] m, input int row, input int col);
    if (row < 1 || row > 10 || col < 1 || col > 20) return 1'b1;
    return m[(row-1)*20 + (col-1)];
  endfunction

  // Orientation codes N=0 S=1 E=2 W=3; clockwise order is N,E,S,W.
  function automatic rstate_t next_state(input logic [199:0] m, input rstate_t s);
    int dr[4];
    int dc[4];
    int cw[4];
    int pos;
    int lo;
    int ro;
    rstate_t n;
    dr[0] = -1; dr[1] = 1; dr[2] = 0; dr[3] = 0;
    dc[0] = 0;  dc[1] = 0; dc[2] = 1; dc[3] = -1;
    cw[0] = 0;  cw[1] = 2; cw[2] = 1; cw[3] = 3;
    pos = 0;
    for (int i = 0; i < 4; i++) if (cw[i] == s.o) pos = i;
    lo = cw[(pos + 3) % 4];
    ro = cw[(pos + 1) % 4];
    n  = s;
    if (!wall_at(m, s.r + dr[lo], s.c + dc[lo])) begin
      n.r = s.r + dr[lo];
      n.c = s.c + dc[lo];
      n.o = lo;
    end else if (!wall_at(m, s.r + dr[s.o], s.c + dc[s.o])) begin
      n.r = s.r + dr[s.o];
      n.c = s.c + dc[s.o];
    end else begin
      n.o = ro;
    end
    return n;
  endfunction

  function automatic logic [31:0] vga_expect(input int p, input rstate_t s, input logic [199:0] m);
    int h;
    int v;
    logic hsx;
    logic vsx;
    logic [23:0] rgb;
    h   = p % 800;
    v   = (p / 800) % 525;
    hsx = !(h >= 656 && h < 752);
    vsx = !(v >= 490 && v < 492);
    rgb = 24'h000000;
    if (h < 640 && v < 320) begin
      if (v / 32 + 1 == s.r && h / 32 + 1 == s.c) rgb = 24'hFF0000;
      else if (wall_at(m, v / 32 + 1, h / 32 + 1)) rgb = 24'h808080;
      else rgb = 24'hFFFFFF;
    end
    return {6'b0, hsx, vsx, rgb};
  endfunction

  function automatic logic [31:0] pack(input int r, input int c, input int o);
    return 32'((r << 9) | (c << 3) | o);
  endfunction

  function automatic logic [31:0] get_state(input int d);
    case (d)
      0:       return pack(int'(u_d.robot_row), int'(u_d.robot_column), int'(u_d.robot_orientation));
      1:       return pack(int'(u_a.robot_row), int'(u_a.robot_column), int'(u_a.robot_orientation));
      default: return pack(int'(u_b.robot_row), int'(u_b.robot_column), int'(u_b.robot_orientation));
    endcase
  endfunction

  function automatic logic [31:0] get_vga(input int d);
    return {6'b0, hs[d], vs[d], red[d], grn[d], blu[d]};
  endfunction

  // Continuous comparison of every DUT against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        if (k / STEP > NACT) begin
          check("model_range", 32'(k), 32'(0));
        end else begin
          mon_s = traj[d][k / STEP];
          check($sformatf("robot%0d k=%0d", d, k), get_state(d), pack(mon_s.r, mon_s.c, mon_s.o));
          if (k == 0) mon_ev = {6'b0, 1'b1, 1'b1, 24'h000000};
          else mon_ev = vga_expect((k - 1) / 2, traj[d][(k - 1) / STEP], map_of(d));
          check($sformatf("vga%0d k=%0d", d, k), get_vga(d), mon_ev);
        end
      end
    end
  end

  task automatic wait_hs(input logic lvl, output int t);
    int n = 0;
    while (hs[0] !== lvl && n < 4000) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    check("hs_wait", {31'b0, hs[0]}, {31'b0, lvl});
  endtask

  initial begin
    int guard;
    int t1;
    int t2;
    int t3;
    clk    = 1'b0;
    KEY    = 4'b0001;
    mon_en = 1'b0;
    n_cmp  = 0;
    n_fail = 0;
    k      = 0;
    cyc    = 0;
    for (int d = 0; d < 3; d++) begin
      traj[d][0] = '{r: 10, c: 1, o: 0};
      for (int i = 0; i < NACT; i++) traj[d][i+1] = next_state(map_of(d), traj[d][i]);
    end
    tbl[0] = '{dut: 0, act: 0,  row: 10, col: 1,  ori: 0};
    tbl[1] = '{dut: 0, act: 9,  row: 1,  col: 1,  ori: 0};
    tbl[2] = '{dut: 0, act: 10, row: 1,  col: 1,  ori: 2};
    tbl[3] = '{dut: 1, act: 11, row: 7,  col: 8,  ori: 2};
    tbl[4] = '{dut: 2, act: 11, row: 7,  col: 8,  ori: 2};
    tbl[5] = '{dut: 1, act: 12, row: 7,  col: 9,  ori: 2};
    tbl[6] = '{dut: 2, act: 12, row: 7,  col: 8,  ori: 1};
    tbl[7] = '{dut: 0, act: 29, row: 1,  col: 20, ori: 2};
    tbl[8] = '{dut: 0, act: 40, row: 10, col: 20, ori: 3};
    tbl[9] = '{dut: 0, act: 60, row: 10, col: 1,  ori: 0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hs", {31'b0, hs[0]}, 32'd1);
    check("rst_vs", {31'b0, vs[0]}, 32'd1);
    KEY    = 4'b0000;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      guard = 0;
      while (k < STEP * tbl[i].act && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      check($sformatf("tbl%0d_time", i), 32'(k), 32'(STEP * tbl[i].act));
      check($sformatf("tbl%0d", i), get_state(tbl[i].dut), pack(tbl[i].row, tbl[i].col, tbl[i].ori));
    end

    for (int i = 0; i < 100; i++) begin
      repeat (2) @(negedge clk);
      check("row_range", 32'(u_d.robot_row >= 6'd1 && u_d.robot_row <= 6'd10), 32'd1);
      check("col_range", 32'(u_d.robot_column >= 6'd1 && u_d.robot_column <= 6'd20), 32'd1);
    end

    // Reset one edge before a pending tick, at action 35 of the loop.
    guard = 0;
    while (k % 120 != 70 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("act35", get_state(0), pack(6, 20, 1));
    @(negedge clk);
    KEY[0] = 1'b1;
    @(negedge clk);
    check("mid_rst", get_state(0), pack(10, 1, 0));
    KEY[0] = 1'b0;
    @(negedge clk);
    check("post_rst_hold", get_state(0), pack(10, 1, 0));
    @(negedge clk);
    check("post_rst_act1", get_state(0), pack(9, 1, 0));

    wait_hs(1'b0, t1);
    wait_hs(1'b1, t2);
    wait_hs(1'b0, t3);
    check("hs_low_cycles", 32'(t2 - t1), 32'd192);
    check("hs_period", 32'(t3 - t1), 32'd1600);

    repeat (150) begin
      repeat ($urandom_range(0, 400)) @(negedge clk);
      KEY[3:1] = 3'($urandom);
      KEY[0]   = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      KEY[0]   = 1'b0;
    end
    repeat (50) @(negedge clk);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
